// File: rtl/aes_key_expand_stream.sv
// aes_key_expand_stream: AES-128 key schedule, round keys 0..LAST_ROUND on a valid/ready stream (KEY_ZEROIZE_EN optional).
// Latency: key 0 valid one cycle after start, then one key per handshake; done pulses the cycle after the last handshake.
// Backpressure: round_key/rk_index/rk_valid hold while rk_valid & !rk_ready; rk_ready has no combinational path to outputs.
module aes_key_expand_stream #(
  parameter int LAST_ROUND = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  localparam logic [3:0] LAST_IDX = 4'(LAST_ROUND);

  state_t       state;
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t, n0, n1, n2, n3;
  logic [127:0] next_key;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 for free.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  assign {w0, w1, w2, w3} = round_key;
  assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rk_valid  <= 1'b0;
      round_key <= 128'h0;
      rk_index  <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rcon      <= 8'h01;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= key_in;
            rk_index  <= 4'd0;
            rcon      <= 8'h01;
            busy      <= 1'b1;
            rk_valid  <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (rk_valid && rk_ready) begin
            if (rk_index == LAST_IDX) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
`ifdef KEY_ZEROIZE_EN
              round_key <= 128'h0;
              rk_index  <= 4'd0;
`endif
            end else begin
              round_key <= next_key;
              rk_index  <= rk_index + 4'd1;
              rcon      <= xtime(rcon);
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_stream.sv
// Bench for aes_key_expand_stream: default LAST_ROUND=10 instance plus a LAST_ROUND=3 instance on a shared clock/reset.
module tb_aes_key_expand_stream;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk, rst;
  logic         start, rk_ready, rk_valid, busy, done;
  logic [127:0] key_in, round_key;
  logic [3:0]   rk_index;
  logic         start3, ready3, valid3, busy3, done3;
  logic [127:0] key3, round_key3;
  logic [3:0]   index3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   sbox_m[256];
  logic [127:0] mk[0:10];

  aes_key_expand_stream dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .round_key(round_key), .rk_index(rk_index), .busy(busy), .done(done)
  );

  aes_key_expand_stream #(.LAST_ROUND(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .key_in(key3), .rk_ready(ready3),
    .rk_valid(valid3), .round_key(round_key3), .rk_index(index3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = tb_xtime(aa);
    end
    return p;
  endfunction

  // Inverse found by exhaustive search, affine transform written bit by bit.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox_m[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w[0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]], sbox_m[temp[31:24]]} ^ {rc, 24'h0};
        rc = tb_xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: always ready, 1: ready toggles, 2: toggling plus random stalls. disturb: start with another key mid-stream.
  task automatic stream_a(input logic [127:0] key, input int mode, input logic [127:0] ck1,
                          input logic [127:0] ck10, input bit disturb);
    exp_t         e;
    int           cyc;
    bit           done_seen, stall_prev;
    logic [127:0] held_key;
    logic [3:0]   held_idx;
    model_expand(key);
    exp_q.delete();
    for (int r = 0; r <= 10; r++) begin
      e.idx = 4'(r);
      e.key = mk[r];
      exp_q.push_back(e);
    end
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    cyc = 0; done_seen = 0; stall_prev = 0; held_key = '0; held_idx = '0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start  = disturb && (cyc == 4);
      key_in = disturb ? ~key : key;
      if (mode == 0)      rk_ready = 1'b1;
      else if (mode == 1) rk_ready = (cyc % 2 == 1);
      else                rk_ready = (cyc % 2 == 1) && ($urandom_range(0, 2) != 0);
      if (stall_prev) begin
        checks++;
        if (round_key !== held_key || rk_index !== held_idx || rk_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold: got key=%h idx=%0d vld=%b want key=%h idx=%0d vld=1",
                   round_key, rk_index, rk_valid, held_key, held_idx);
        end
      end
      if (done) begin
        done_seen = 1;
        if (mode == 0) begin
          checks++;
          if (cyc !== 12) begin
            failures++;
            $display("FAIL done_latency: got %0d cycles want 12", cyc);
          end
        end
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL done_state: got vld=%b busy=%b pending=%0d want vld=0 busy=0 pending=0",
                   rk_valid, busy, exp_q.size());
        end
        checks++;
`ifdef KEY_ZEROIZE_EN
        if (round_key !== 128'h0 || rk_index !== 4'd0) begin
          failures++;
          $display("FAIL final_key: got %h idx=%0d want 0 idx=0", round_key, rk_index);
        end
`else
        if (round_key !== mk[10] || rk_index !== 4'd10) begin
          failures++;
          $display("FAIL final_key: got %h idx=%0d want %h idx=10", round_key, rk_index, mk[10]);
        end
`endif
      end else if (rk_valid) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_while_valid: got %b want 1", busy);
        end
        if (rk_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_key: got idx=%0d key=%h want none", rk_index, round_key);
          end else begin
            e = exp_q.pop_front();
            if (round_key !== e.key || rk_index !== e.idx) begin
              failures++;
              $display("FAIL key_stream: got idx=%0d key=%h want idx=%0d key=%h", rk_index, round_key, e.idx, e.key);
            end
            if (e.idx == 4'd1) begin
              checks++;
              if (round_key !== ck1) begin
                failures++;
                $display("FAIL vector_k1: got %h want %h", round_key, ck1);
              end
            end
            if (e.idx == 4'd10) begin
              checks++;
              if (round_key !== ck10) begin
                failures++;
                $display("FAIL vector_k10: got %h want %h", round_key, ck10);
              end
            end
          end
        end
      end
      stall_prev = rk_valid && !rk_ready;
      held_key   = round_key;
      held_idx   = rk_index;
    end
    start = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL done_timeout: got no done in %0d cycles want done", cyc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle: got %b want 0", done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_key !== 128'h0 || rk_index !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: got vld=%b busy=%b done=%b key=%h idx=%0d want all zero",
               rk_valid, busy, done, round_key, rk_index);
    end
    checks++;
    if (valid3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0 || round_key3 !== 128'h0) begin
      failures++;
      $display("FAIL reset_state3: got vld=%b busy=%b done=%b key=%h want all zero", valid3, busy3, done3, round_key3);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips();           stream_a(FIPS_KEY, 0, FIPS_K1, FIPS_K10, 1'b0); endtask
  task automatic test_backpressure();   stream_a(FIPS_KEY, 1, FIPS_K1, FIPS_K10, 1'b0); endtask
  task automatic test_random_stall();   stream_a(FIPS_KEY, 2, FIPS_K1, FIPS_K10, 1'b0); endtask
  task automatic test_zero_key();       stream_a(128'h0, 0, ZERO_K1, ZERO_K10, 1'b0); endtask
  task automatic test_start_while_busy(); stream_a(FIPS_KEY, 0, FIPS_K1, FIPS_K10, 1'b1); endtask

  task automatic test_reset_mid();
    bit found, done_any;
    rk_ready = 1'b1;
    @(negedge clk);
    key_in = FIPS_KEY;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rk_valid && rk_index == 4'd5) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_index5: got idx=%0d want 5", rk_index);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || round_key !== 128'h0 || rk_index !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset: got vld=%b busy=%b key=%h idx=%0d want all zero", rk_valid, busy, round_key, rk_index);
    end
    done_any = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      done_any |= done;
    end
    rst = 1'b0;
    @(negedge clk);
    done_any |= done;
    checks++;
    if (done_any) begin
      failures++;
      $display("FAIL mid_reset_done: got done pulse want none");
    end
    stream_a(FIPS_KEY, 0, FIPS_K1, FIPS_K10, 1'b0);
  endtask

  task automatic test_last_round3();
    int cyc, acc;
    bit done_seen;
    model_expand(FIPS_KEY);
    @(negedge clk);
    key3   = FIPS_KEY;
    start3 = 1'b1;
    cyc = 0; acc = 0; done_seen = 0;
    while (!done_seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start3 = 1'b0;
      ready3 = (cyc % 3 != 0);
      if (done3) done_seen = 1;
      else if (valid3 && ready3) begin
        checks++;
        if (acc > 3) begin
          failures++;
          $display("FAIL last3_extra: got idx=%0d want no more keys", index3);
        end else if (round_key3 !== mk[acc] || index3 !== 4'(acc)) begin
          failures++;
          $display("FAIL last3_key: got idx=%0d key=%h want idx=%0d key=%h", index3, round_key3, acc, mk[acc]);
        end
        acc++;
      end
    end
    checks++;
    if (!done_seen || acc != 4 || busy3 !== 1'b0 || valid3 !== 1'b0) begin
      failures++;
      $display("FAIL last3_done: got done=%b keys=%0d busy=%b vld=%b want done=1 keys=4 busy=0 vld=0",
               done_seen, acc, busy3, valid3);
    end
    checks++;
`ifdef KEY_ZEROIZE_EN
    if (round_key3 !== 128'h0 || index3 !== 4'd0) begin
      failures++;
      $display("FAIL last3_final: got %h idx=%0d want 0 idx=0", round_key3, index3);
    end
`else
    if (round_key3 !== mk[3] || index3 !== 4'd3) begin
      failures++;
      $display("FAIL last3_final: got %h idx=%0d want %h idx=3", round_key3, index3, mk[3]);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; rk_ready = 1'b0; key_in = '0;
    start3 = 1'b0; ready3 = 1'b0; key3 = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_backpressure();
    test_random_stall();
    test_zero_key();
    test_start_while_busy();
    test_reset_mid();
    test_last_round3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
